// File: rtl/heartbeat_pkg.sv
// Shared types and default parameters for the heartbeat monitor.
// The optional HEARTBEAT_PERIOD_CAPTURE_EN macro is consumed by heartbeat_monitor.
package heartbeat_pkg;

   // Period measurement: idle until the first edge, then timing edge to edge
   typedef enum logic {
      DISARMED = 1'b0,
      ARMED    = 1'b1
   } meas_state_e;

   // CPU liveness verdict
   typedef enum logic {
      DEAD  = 1'b0,
      ALIVE = 1'b1
   } live_state_e;

   localparam int DEF_CNT_W      = 24;
   localparam int DEF_MIN_PERIOD = 20000;
   localparam int DEF_MAX_PERIOD = 60000;
   localparam int DEF_MIN_WIDTH  = 4;
   localparam int DEF_GOOD_CNT   = 4;
   localparam int DEF_BAD_CNT    = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hb_sync_qual.sv
// Heartbeat input conditioning: 2-flop synchronizer followed by a
// high-run qualifier. qe pulses for exactly one cycle when the synced
// input has been high for MIN_WIDTH consecutive cycles.
module hb_sync_qual
   import heartbeat_pkg::*;
#(
   parameter int MIN_WIDTH = DEF_MIN_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm,
   output logic qe
);

   localparam int SYNC_STAGES = 2;
   localparam int HW          = $clog2(MIN_WIDTH + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [HW-1:0]          hcnt_q;
   logic [HW-1:0]          hcnt_d;
   logic                   synced;

   // Synchronizer chain: stage 0 takes the raw pin, each later stage the previous one
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = pwm;
         end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   assign synced = sync_q[SYNC_STAGES-1];

   // High-run counter: clears on a synced low, saturates at MIN_WIDTH
   always_comb begin
      hcnt_d = hcnt_q;
      if (!synced) begin
         hcnt_d = '0;
      end else if (hcnt_q != HW'(MIN_WIDTH)) begin
         hcnt_d = hcnt_q + HW'(1);
      end
   end

   // Synchronizer and run-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hcnt_q <= '0;
      end else begin
         sync_q <= sync_d;
         hcnt_q <= hcnt_d;
      end
   end

   // Fires on the cycle the run completes its MIN_WIDTH-th high sample;
   // saturation keeps it from repeating while the pin stays high.
   assign qe = synced && (hcnt_q == HW'(MIN_WIDTH - 1));

endmodule

// File: rtl/heartbeat_monitor.sv
// Per-CPU heartbeat checker: qualifies heartbeat edges, measures the
// edge-to-edge period against [MIN_PERIOD, MAX_PERIOD] and debounces the
// good/bad verdicts into an alive flag (io).
// Optional: define HEARTBEAT_PERIOD_CAPTURE_EN to add the period_o port.
module heartbeat_monitor
   import heartbeat_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int MAX_PERIOD = DEF_MAX_PERIOD,
   parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
   parameter int GOOD_CNT   = DEF_GOOD_CNT,
   parameter int BAD_CNT    = DEF_BAD_CNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm,
   output logic             io,
   output logic             good_evt,
   output logic             bad_evt
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
   ,
   output logic [CNT_W-1:0] period_o
`endif
);

   localparam int RUN_W = $clog2(max_int(GOOD_CNT, BAD_CNT) + 1);

   logic             qe;
   meas_state_e      meas_q, meas_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_w;
   logic             in_window;
   logic             good_evt_q, good_evt_d;
   logic             bad_evt_q, bad_evt_d;
   live_state_e      live_q, live_d;
   logic [RUN_W-1:0] good_run_q, good_run_d;
   logic [RUN_W-1:0] bad_run_q, bad_run_d;

   hb_sync_qual #(
      .MIN_WIDTH (MIN_WIDTH)
   ) u_sync_qual (
      .clk   (clk),
      .rst_n (rst_n),
      .pwm   (pwm),
      .qe    (qe)
   );

   // The counter lags the true edge distance by one, hence the +1; a QE
   // coincident with timeout therefore yields MAX_PERIOD+1, which is bad.
   assign period_w  = cnt_q + CNT_W'(1);
   assign in_window = (period_w >= CNT_W'(MIN_PERIOD)) && (period_w <= CNT_W'(MAX_PERIOD));

   // Measurement FSM: period counting, verdict on each edge, timeout disarms
   always_comb begin
      meas_d     = meas_q;
      cnt_d      = cnt_q;
      good_evt_d = 1'b0;
      bad_evt_d  = 1'b0;
      case (meas_q)
         DISARMED: begin
            cnt_d = '0;
            if (qe) begin
               meas_d = ARMED;
            end
         end
         ARMED: begin
            if (qe) begin
               cnt_d = '0;
               if (in_window) begin
                  good_evt_d = 1'b1;
               end else begin
                  bad_evt_d = 1'b1;
               end
            end else if (cnt_q == CNT_W'(MAX_PERIOD)) begin
               cnt_d     = '0;
               bad_evt_d = 1'b1;
               meas_d    = DISARMED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            meas_d = DISARMED;
            cnt_d  = '0;
         end
      endcase
   end

   // Liveness FSM: GOOD_CNT good periods in a row to revive, BAD_CNT bad to kill
   always_comb begin
      live_d     = live_q;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      case (live_q)
         DEAD: begin
            if (good_evt_q) begin
               if (good_run_q + RUN_W'(1) == RUN_W'(GOOD_CNT)) begin
                  live_d     = ALIVE;
                  good_run_d = '0;
                  bad_run_d  = '0;
               end else begin
                  good_run_d = good_run_q + RUN_W'(1);
               end
            end else if (bad_evt_q) begin
               good_run_d = '0;
            end
         end
         ALIVE: begin
            if (bad_evt_q) begin
               if (bad_run_q + RUN_W'(1) == RUN_W'(BAD_CNT)) begin
                  live_d     = DEAD;
                  good_run_d = '0;
                  bad_run_d  = '0;
               end else begin
                  bad_run_d = bad_run_q + RUN_W'(1);
               end
            end else if (good_evt_q) begin
               bad_run_d = '0;
            end
         end
         default: begin
            live_d     = DEAD;
            good_run_d = '0;
            bad_run_d  = '0;
         end
      endcase
   end

   // State, counter and event-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_q     <= DISARMED;
         cnt_q      <= '0;
         good_evt_q <= 1'b0;
         bad_evt_q  <= 1'b0;
         live_q     <= DEAD;
         good_run_q <= '0;
         bad_run_q  <= '0;
      end else begin
         meas_q     <= meas_d;
         cnt_q      <= cnt_d;
         good_evt_q <= good_evt_d;
         bad_evt_q  <= bad_evt_d;
         live_q     <= live_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
      end
   end

   assign io       = (live_q == ALIVE);
   assign good_evt = good_evt_q;
   assign bad_evt  = bad_evt_q;

`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
   logic [CNT_W-1:0] period_q, period_d;

   // Capture every evaluated period (good or bad); timeouts leave it untouched
   always_comb begin
      period_d = period_q;
      if ((meas_q == ARMED) && qe) begin
         period_d = period_w;
      end
   end

   // Captured-period register, aligned with the event pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= '0;
      end else begin
         period_q <= period_d;
      end
   end

   assign period_o = period_q;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scoreboard bench for heartbeat_monitor: stimulus predicts event pulses
// from edge timestamps; a negedge monitor pops and compares them.
module tb_heartbeat_monitor;

   localparam int CNT_W = 12;
   localparam int MINP  = 100;
   localparam int MAXP  = 200;
   localparam int MW    = 4;
   localparam int GC    = 4;
   localparam int BC    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic pwm   = 1'b0;
   logic io, good_evt, bad_evt;
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
   logic [CNT_W-1:0] period_o;
`endif

   heartbeat_monitor #(
      .CNT_W      (CNT_W),
      .MIN_PERIOD (MINP),
      .MAX_PERIOD (MAXP),
      .MIN_WIDTH  (MW),
      .GOOD_CNT   (GC),
      .BAD_CNT    (BC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm      (pwm),
      .io       (io),
      .good_evt (good_evt),
      .bad_evt  (bad_evt)
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
      ,
      .period_o (period_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit good;
      int period;
      bit io_before;
      bit io_after;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: edge timestamps and run counts
   int run;
   bit armed;
   int last_qe;
   bit m_alive;
   int m_good_run;
   int m_bad_run;
   int m_last_p;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      run        = 0;
      armed      = 0;
      last_qe    = 0;
      m_alive    = 0;
      m_good_run = 0;
      m_bad_run  = 0;
      m_last_p   = 0;
      exp_q.delete();
   endtask

   // Record a verdict made at cycle c; its pulse appears at c+1
   task automatic model_event(input int c, input bit good, input int p, input bit is_qe);
      exp_t e;
      e.cyc       = c + 1;
      e.good      = good;
      e.io_before = m_alive;
      if (is_qe) m_last_p = p;
      e.period = m_last_p;
      if (!m_alive) begin
         if (good) begin
            m_good_run++;
            if (m_good_run == GC) begin
               m_alive = 1; m_good_run = 0; m_bad_run = 0;
            end
         end else begin
            m_good_run = 0;
         end
      end else begin
         if (!good) begin
            m_bad_run++;
            if (m_bad_run == BC) begin
               m_alive = 0; m_good_run = 0; m_bad_run = 0;
            end
         end else begin
            m_bad_run = 0;
         end
      end
      e.io_after = m_alive;
      exp_q.push_back(e);
   endtask

   // Drive one pin sample; it is seen by the qualifier as the edge lands at cycle cyc+2
   task automatic step(input logic v);
      int c;
      bit qe;
      @(negedge clk);
      pwm = v;
      c   = cyc + 2;
      run = v ? run + 1 : 0;
      qe  = (run == MW);
      if (!armed) begin
         if (qe) begin
            armed   = 1;
            last_qe = c;
         end
      end else if (qe) begin
         model_event(c, (c - last_qe >= MINP) && (c - last_qe <= MAXP), c - last_qe, 1);
         last_qe = c;
      end else if (c - last_qe == MAXP + 1) begin
         model_event(c, 0, 0, 0);
         armed = 0;
      end
   endtask

   task automatic pulse(input int p, input int w);
      repeat (w) step(1'b1);
      repeat (p - w) step(1'b0);
   endtask

   task automatic glitch_pulse();
      repeat (75) step(1'b1);
      repeat (30) step(1'b0);
      repeat (3)  step(1'b1);
      repeat (42) step(1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      pwm   = 1'b0;
      model_reset();
      #1;
      check({tag, "_io"}, io, 0);
      check({tag, "_good_evt"}, good_evt, 0);
      check({tag, "_bad_evt"}, bad_evt, 0);
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
      check({tag, "_period_o"}, period_o, 0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops an expectation whenever the DUT pulses an event
   bit pend;
   bit pend_io;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         pend = 0;
      end else begin
         if (pend) begin
            check("io_after_evt", io, pend_io);
            pend = 0;
         end
         if (good_evt || bad_evt) begin
            check("evt_exclusive", good_evt && bad_evt, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_evt: got good=%0b bad=%0b, required none (cycle %0d)",
                        good_evt, bad_evt, cyc);
            end else begin
               e = exp_q.pop_front();
               check("evt_cycle", cyc, e.cyc);
               check("evt_good", good_evt, e.good);
               check("io_at_evt", io, e.io_before);
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
               check("period_o", period_o, e.period);
`endif
               pend    = 1;
               pend_io = e.io_after;
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missing_evt_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      model_reset();
      pend = 0;
      repeat (2) @(negedge clk);
      do_reset("reset");

      // Square wave, period 150
      repeat (6) pulse(150, 75);
      check("sq_alive", io, 1);

      // Stuck low: timeout, re-arm edge, second timeout -> dead
      idle(250);
      pulse(150, 75);
      idle(250);
      check("stuck_dead", io, 0);

      // Revive, then a single short period is tolerated
      repeat (6) pulse(150, 75);
      pulse(80, 40);
      pulse(150, 75);
      pulse(150, 75);
      check("short_tolerated", io, 1);

      // Glitches inside the low phase are ignored
      do_reset("glitch_rst");
      repeat (7) glitch_pulse();
      check("glitch_alive", io, 1);

      // Boundary periods: 100, 200 good; 99, 201 bad
      pulse(100, 20);
      pulse(200, 20);
      pulse(99, 20);
      pulse(201, 20);
      pulse(150, 20);
      pulse(150, 20);

      // Reset mid-period while alive
      repeat (6) pulse(150, 75);
      repeat (75) step(1'b1);
      repeat (20) step(1'b0);
      do_reset("mid_rst");
      repeat (3) pulse(150, 75);

      // Randomized periods, widths (some sub-qualifying) and gaps
      for (int i = 0; i < 120; i++) begin
         int p;
         int w;
         p = $urandom_range(215, 90);
         if ($urandom_range(19, 0) == 0) p += 200;
         w = ($urandom_range(9, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(40, 4);
         pulse(p, w);
      end

      idle(2 * MAXP + 50);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
